// File: rtl/arith_pkg.sv
// arith_pkg: shared types and widths for the integer arithmetic unit
package arith_pkg;
    localparam int ARITH_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, RUN, FIX} mul_state_t;
endpackage

// File: rtl/mul_step.sv
// mul_step: one shift-add iteration over the {carry, hi, lo} chain
module mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);
    logic [WIDTH:0] sum;
    assign sum = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : '0);
    assign {hi_next, lo_next} = {sum, lo[WIDTH-1:1]};
endmodule

// File: rtl/mul32_seq.sv
// mul32_seq: sequential signed/unsigned shift-add multiplier, one multiplier bit per clock
module mul32_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    mul_state_t state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, mag_a, hi_next, lo_next, abs_a, abs_b;
    logic             neg;
    // Magnitude of the most negative value wraps to itself, which is correct as unsigned
    assign abs_a = (is_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign abs_b = (is_signed && multiplier[WIDTH-1]) ? -multiplier : multiplier;
    assign busy  = state != IDLE;
    mul_step #(.WIDTH(WIDTH)) u_step (
        .hi      (hi),
        .lo      (lo),
        .mag_a   (mag_a),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );
    always_comb begin
        state_next = state;
        state_next = (state == IDLE) ? (start ? RUN : IDLE) :
                     (state == RUN)  ? ((cnt == CW'(WIDTH - 1)) ? FIX : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            mag_a   <= '0;
            neg     <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            state <= state_next;
            done  <= state == FIX;
            if (state == IDLE && start) begin
                hi    <= '0;
                lo    <= abs_b;
                mag_a <= abs_a;
                neg   <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                cnt   <= '0;
            end else if (state == RUN) begin
                hi  <= hi_next;
                lo  <= lo_next;
                cnt <= cnt + 1'b1;
            end
            if (state == FIX)
                product <= neg ? -{hi, lo} : {hi, lo};
        end
    end
endmodule

// File: tb/tb_mul32_seq.sv
// tb_mul32_seq: randomized and directed checks of mul32_seq against an arithmetic reference
module tb_mul32_seq;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic        is_signed = 0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        busy, done;
    logic [63:0] product;
    int total = 0;
    int bad = 0;

    mul32_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        return 64'(sa * sb);
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [63:0] p, output int lat, output bit busy_ok, output bit pulse_ok);
        @(negedge clk);
        start = 1; is_signed = s; multiplicand = a; multiplier = b;
        @(negedge clk);
        start = 0;
        lat = 0; busy_ok = 1;
        while (!done && lat < 100) begin
            busy_ok &= busy;
            @(negedge clk);
            lat++;
        end
        busy_ok &= !busy;
        p = product;
        @(negedge clk);
        pulse_ok = !done && (product == p);
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({busy, done, product} !== 66'b0) begin
            bad++; $display("FAIL reset_state busy=%b done=%b product=%h want 0", busy, done, product);
        end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_unsigned;
        logic [63:0] p; int lat; bit bo, po;
        run_op(32'd13, 32'd3, 1'b0, p, lat, bo, po);
        total++;
        if (p !== 64'd39) begin bad++; $display("FAIL unsigned_13x3 got=%h want=%h", p, 64'd39); end
        total++;
        if (lat !== 33) begin bad++; $display("FAIL unsigned_latency got=%0d want=33", lat); end
        total++;
        if (!bo) begin bad++; $display("FAIL unsigned_busy got=0 want=1 while running and 0 at done"); end
        total++;
        if (!po) begin bad++; $display("FAIL unsigned_done_pulse got=wide want=1 cycle"); end
    endtask

    task automatic test_signed;
        logic [63:0] p; int lat; bit bo, po;
        run_op(32'hFFFFFFF9, 32'd6, 1'b1, p, lat, bo, po);
        total++;
        if (p !== 64'hFFFFFFFFFFFFFFD6) begin bad++; $display("FAIL signed_m7x6 got=%h want=FFFFFFFFFFFFFFD6", p); end
        run_op(32'hFFFFFFF9, 32'd6, 1'b0, p, lat, bo, po);
        total++;
        if (p !== 64'h00000005FFFFFFD6) begin bad++; $display("FAIL unsigned_m7x6 got=%h want=00000005FFFFFFD6", p); end
    endtask

    task automatic test_extremes;
        logic [63:0] p; int lat; bit bo, po;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, p, lat, bo, po);
        total++;
        if (p !== 64'hFFFFFFFE00000001) begin bad++; $display("FAIL umax_sq got=%h want=FFFFFFFE00000001", p); end
        run_op(32'h80000000, 32'h80000000, 1'b1, p, lat, bo, po);
        total++;
        if (p !== 64'h4000000000000000) begin bad++; $display("FAIL smin_sq got=%h want=4000000000000000", p); end
        run_op(32'h80000000, 32'd1, 1'b1, p, lat, bo, po);
        total++;
        if (p !== 64'hFFFFFFFF80000000) begin bad++; $display("FAIL smin_x1 got=%h want=FFFFFFFF80000000", p); end
        run_op(32'd0, 32'hFFFFFFF0, 1'b1, p, lat, bo, po);
        total++;
        if (p !== 64'd0) begin bad++; $display("FAIL zero_x_neg got=%h want=0", p); end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        start = 1; is_signed = 0; multiplicand = 32'd100; multiplier = 32'd7;
        @(negedge clk);
        start = 0;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            start = (lat == 5 || lat == 20);
            if (start) begin
                is_signed = 1; multiplicand = 32'hFFFF0000 + 32'(lat); multiplier = 32'h8000_0003;
            end
        end
        start = 0;
        total++;
        if (lat !== 33) begin bad++; $display("FAIL ignore_latency got=%0d want=33", lat); end
        total++;
        if (product !== 64'd700) begin bad++; $display("FAIL ignore_product got=%h want=%h", product, 64'd700); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_restart busy=%b want=0", busy); end
    endtask

    task automatic test_back_to_back;
        int lat, n;
        @(negedge clk);
        start = 1; is_signed = 1; multiplicand = 32'hFFFFFF00; multiplier = 32'd3;
        @(negedge clk);
        start = 0;
        lat = 0;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        total++;
        if (product !== ref_mul(32'hFFFFFF00, 32'd3, 1'b1)) begin
            bad++; $display("FAIL b2b_first got=%h want=%h", product, ref_mul(32'hFFFFFF00, 32'd3, 1'b1));
        end
        start = 1; is_signed = 0; multiplicand = 32'h12345678; multiplier = 32'h9ABCDEF0;
        @(negedge clk);
        start = 0;
        n = 1;
        while (!done && n < 100) begin @(negedge clk); n++; end
        total++;
        if (n !== 34) begin bad++; $display("FAIL b2b_spacing got=%0d want=34", n); end
        total++;
        if (product !== ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b0)) begin
            bad++; $display("FAIL b2b_second got=%h want=%h", product, ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b0));
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] p; int lat; bit bo, po, seen;
        @(negedge clk);
        start = 1; is_signed = 0; multiplicand = 32'd55; multiplier = 32'd66;
        @(negedge clk);
        start = 0;
        repeat (10) @(negedge clk);
        rst_n = 0;
        #1;
        total++;
        if ({busy, done, product} !== 66'b0) begin
            bad++; $display("FAIL midreset_clear busy=%b done=%b product=%h want 0", busy, done, product);
        end
        @(negedge clk); rst_n = 1;
        seen = 0;
        repeat (40) begin @(negedge clk); seen |= done | busy; end
        total++;
        if (seen) begin bad++; $display("FAIL midreset_discard got=activity want=idle"); end
        run_op(32'd0, 32'd12345, 1'b0, p, lat, bo, po);
        total++;
        if (p !== 64'd0 || lat !== 33 || !po) begin
            bad++; $display("FAIL after_reset got=%h lat=%0d pulse=%b want=0 lat=33 pulse=1", p, lat, po);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [63:0] p, exp; logic [31:0] a, b; logic s; int lat; bit bo, po;
        for (int i = 0; i < 1000; i++) begin
            a = pick_operand(); b = pick_operand(); s = 1'($urandom_range(0, 1));
            exp = ref_mul(a, b, s);
            run_op(a, b, s, p, lat, bo, po);
            total++;
            if (p !== exp || lat !== 33 || !bo || !po) begin
                bad++;
                $display("FAIL random_%0d a=%h b=%h s=%b got=%h lat=%0d busy=%b pulse=%b want=%h lat=33 busy=1 pulse=1",
                         i, a, b, s, p, lat, bo, po, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_extremes();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
